rr_arbiter5: RTL and testbench
==============================

RR_ARBITER5 -- requirements
Module: rr_arbiter5

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one requester may hold the grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 5 bits: request from requester i (bit i) for the shared 32-bit mux5 output bus.
REQ-005 The block SHALL have port gnt, output, 5 bits: one-hot registered grant; bit i high means requester i owns the bus.
REQ-006 The block SHALL have port select, output, 3 bits: mux5 select value; requester i maps to select = i (Src1..Src5 = 0..4).
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever any gnt bit is high.

Function
REQ-008 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-009 gnt SHALL be zero or one-hot in every cycle; two bits high at once is illegal.
REQ-010 In IDLE, if req != 0 at a rising edge, the block SHALL enter GRANT with the winner's gnt bit high after that edge (1-cycle latency, req to gnt).
REQ-011 Winner selection SHALL be round-robin: search starts at index (last+1) mod 5, where last is the most recently granted index (reset value 4, so index 0 wins first).
REQ-012 A hold counter SHALL clear to 0 on every new grant and increment each cycle the grant is kept.
REQ-013 In GRANT, the grant SHALL be kept while req[g] is high and hold count < MAX_HOLD-1.
REQ-014 Release on req[g] low: if other requests are pending, the next RR winner SHALL be granted at the same edge (no idle cycle); otherwise the block SHALL return to IDLE.
REQ-015 Release on hold expiry (count = MAX_HOLD-1, req[g] still high): g SHALL have lowest priority.
REQ-016 On hold expiry with another request pending, that other requester SHALL win; if g is the only requester, g SHALL be re-granted with the counter cleared.
REQ-017 The block SHALL update last to the granted index on every grant, including a re-grant.
REQ-018 select SHALL equal the encoded index of the current grant; in IDLE select SHALL hold its last value (the mux output is don't-care when busy is low).
REQ-019 busy SHALL be the OR of gnt and change in the same cycle as gnt.
REQ-020 Requests arriving or dropping mid-grant for non-granted indices SHALL NOT affect the current grant.
REQ-021 With MAX_HOLD = 1, every grant SHALL last exactly one cycle, rotating among all active requesters.

Reset
REQ-022 While rst is low, gnt SHALL be 5'b00000, select 3'd0, busy 0, the state IDLE, the hold count 0 and last 4, independent of clk.
REQ-023 Asserting rst mid-grant SHALL clear the outputs immediately (asynchronously).
REQ-024 After rst deasserts, the first rising edge with req != 0 SHALL grant per REQ-011 from last = 4.

Verification
REQ-025 Reset then req=5'b11111 held, MAX_HOLD=4 -> gnt 00001 for 4 cycles, then 00010, 00100, 01000, 10000, each for 4 cycles; select 0,1,2,3,4; busy stays 1.
REQ-026 req=5'b00100 held alone -> gnt 00100 from the next edge and never drops; re-grant every 4 cycles; select=2 throughout.
REQ-027 Grant on index 1, req[1] drops with req[3] high -> gnt 01000 on the next edge, with no IDLE cycle and busy continuously 1.
REQ-028 Single request pulse req=5'b10000 for 1 cycle -> gnt 10000 for 1 cycle, then IDLE: gnt 0, busy 0, select held at 4.
REQ-029 rst driven low between clock edges while gnt=00010 -> gnt 0, busy 0, select 0 immediately; after release with req=5'b00011 -> gnt 00001 first.
REQ-030 Run all cycles with random req -> gnt is never multi-hot, and select always matches gnt when busy=1.

Source files
------------

// File: rtl/rr_arbiter5.sv
// Five-way round-robin bus arbiter with a per-grant hold limit.
// Drives the one-hot grant, the mux5 select value and a busy flag.
module rr_arbiter5 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    output logic [4:0] gnt,
    output logic [2:0] select,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [4:0] gnt_q,   gnt_d;
    logic [2:0] sel_q,   sel_d;
    logic [2:0] last_q,  last_d;
    logic [3:0] hold_q,  hold_d;

    logic       rr_found;
    logic [2:0] rr_idx;
    logic [2:0] cand;
    logic       take;

    // Search starts just after the last grant, so the current owner (== last)
    // is naturally examined last and only wins when nobody else is requesting.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 3'd0;
        cand     = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            cand = 3'((int'(last_q) + i) % 5);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        take    = 1'b0;

        case (state_q)
            IDLE:  take = 1'b1;
            GRANT: begin
                if (req[sel_q] && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    take = 1'b1;
                end
            end
            default: take = 1'b1;
        endcase

        if (take) begin
            hold_d = 4'd0;
            if (rr_found) begin
                state_d = GRANT;
                gnt_d   = 5'b00001 << rr_idx;
                sel_d   = rr_idx;
                last_d  = rr_idx;
            end else begin
                // Select keeps its last value while idle.
                state_d = IDLE;
                gnt_d   = 5'b00000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 5'b00000;
            sel_q   <= 3'd0;
            last_q  <= 3'd4;
            hold_q  <= 4'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt    = gnt_q;
    assign select = sel_q;
    assign busy   = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter5.sv
// Self-checking bench for rr_arbiter5: directed scenarios plus random traffic
// compared against a behavioural owner/held-cycles model (MAX_HOLD 4 and 1).
module tb_rr_arbiter5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req = 5'b00000;

    logic [4:0] gnt0, gnt1;
    logic [2:0] sel0, sel1;
    logic       busy0, busy1;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_arbiter5 #(.MAX_HOLD(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .select(sel0), .busy(busy0)
    );

    rr_arbiter5 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .select(sel1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, for how many cycles so far, and who
    // was granted most recently. Index 0 models MAX_HOLD=4, index 1 MAX_HOLD=1.
    int         m_owner[2];
    int         m_held[2];
    int         m_last[2];
    logic [2:0] m_sel[2];
    int         lim[2] = '{4, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_last[k]  = 4;
            m_sel[k]   = 3'd0;
        end
    endtask

    task automatic model_edge(input int k, input logic [4:0] r);
        if (m_owner[k] >= 0 && r[m_owner[k]] && m_held[k] < lim[k]) begin
            m_held[k]++;
        end else begin
            m_owner[k] = -1;
            for (int i = 1; i <= 5; i++) begin
                int c;
                c = (m_last[k] + i) % 5;
                if (r[c]) begin
                    m_owner[k] = c;
                    m_held[k]  = 1;
                    m_last[k]  = c;
                    m_sel[k]   = 3'(c);
                    break;
                end
            end
        end
    endtask

    function automatic logic [8:0] exp_vec(input int k);
        logic [4:0] g;
        g = (m_owner[k] >= 0) ? 5'(1 << m_owner[k]) : 5'd0;
        return {g, m_sel[k], |g};
    endfunction

    // Advance one rising edge with the current req, then settle past it.
    task automatic tick();
        model_edge(0, req);
        model_edge(1, req);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 5'b11111;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({gnt0, sel0, busy0} !== 9'd0 || {gnt1, sel1, busy1} !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got gnt=%b sel=%0d busy=%b / gnt=%b sel=%0d busy=%b, want all zero",
                         gnt0, sel0, busy0, gnt1, sel1, busy1);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        req = 5'b00000;
    endtask

    task automatic test_rotation();
        logic [8:0] want;
        do_reset();
        req = 5'b11111;
        for (int c = 0; c <= 20; c++) begin
            tick();
            want = {5'(1 << ((c / 4) % 5)), 3'((c / 4) % 5), 1'b1};
            n_cmp++;
            if ({gnt0, sel0, busy0} !== want) begin
                n_fail++;
                $display("FAIL rotation c=%0d: got gnt=%b sel=%0d busy=%b, want %b",
                         c, gnt0, sel0, busy0, want);
            end
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 5'b00100;
        for (int c = 0; c < 13; c++) begin
            tick();
            n_cmp++;
            if ({gnt0, sel0, busy0} !== {5'b00100, 3'd2, 1'b1}) begin
                n_fail++;
                $display("FAIL single_hold c=%0d: got gnt=%b sel=%0d busy=%b, want gnt=00100 sel=2 busy=1",
                         c, gnt0, sel0, busy0);
            end
        end
    endtask

    task automatic test_handoff();
        logic [4:0] seq[4] = '{5'b00010, 5'b01010, 5'b01000, 5'b01000};
        logic [4:0] want[4] = '{5'b00010, 5'b00010, 5'b01000, 5'b01000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req = seq[c];
            tick();
            n_cmp++;
            if (gnt0 !== want[c] || busy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL handoff c=%0d: got gnt=%b busy=%b, want gnt=%b busy=1",
                         c, gnt0, busy0, want[c]);
            end
        end
    endtask

    task automatic test_pulse();
        do_reset();
        req = 5'b10000;
        tick();
        n_cmp++;
        if ({gnt0, sel0, busy0} !== {5'b10000, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL pulse_grant: got gnt=%b sel=%0d busy=%b, want gnt=10000 sel=4 busy=1",
                     gnt0, sel0, busy0);
        end
        req = 5'b00000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({gnt0, sel0, busy0} !== {5'b00000, 3'd4, 1'b0}) begin
                n_fail++;
                $display("FAIL pulse_idle c=%0d: got gnt=%b sel=%0d busy=%b, want gnt=00000 sel=4 busy=0",
                         c, gnt0, sel0, busy0);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 5'b00010;
        tick();
        n_cmp++;
        if (gnt0 !== 5'b00010) begin
            n_fail++;
            $display("FAIL async_setup: got gnt=%b, want 00010", gnt0);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt0, sel0, busy0} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_clear: got gnt=%b sel=%0d busy=%b, want all zero", gnt0, sel0, busy0);
        end
        @(negedge clk);
        rst = 1'b1;
        req = 5'b00011;
        tick();
        n_cmp++;
        if ({gnt0, sel0, busy0} !== {5'b00001, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_restart: got gnt=%b sel=%0d busy=%b, want gnt=00001 sel=0 busy=1",
                     gnt0, sel0, busy0);
        end
    endtask

    task automatic test_max_hold1();
        do_reset();
        req = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({gnt1, sel1, busy1} !== {5'(1 << (c % 5)), 3'(c % 5), 1'b1}) begin
                n_fail++;
                $display("FAIL max_hold1_rotate c=%0d: got gnt=%b sel=%0d busy=%b, want gnt=%b",
                         c, gnt1, sel1, busy1, 5'(1 << (c % 5)));
            end
        end
        req = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (gnt1 !== 5'b01000 || sel1 !== 3'd3) begin
                n_fail++;
                $display("FAIL max_hold1_alone c=%0d: got gnt=%b sel=%0d, want gnt=01000 sel=3",
                         c, gnt1, sel1);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] w0, w1;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 5'($urandom);
            tick();
            w0 = exp_vec(0);
            w1 = exp_vec(1);
            n_cmp++;
            if ({gnt0, sel0, busy0} !== w0) begin
                n_fail++;
                $display("FAIL random_h4 c=%0d req=%b: got gnt=%b sel=%0d busy=%b, want %b",
                         c, req, gnt0, sel0, busy0, w0);
            end
            n_cmp++;
            if ({gnt1, sel1, busy1} !== w1) begin
                n_fail++;
                $display("FAIL random_h1 c=%0d req=%b: got gnt=%b sel=%0d busy=%b, want %b",
                         c, req, gnt1, sel1, busy1, w1);
            end
            n_cmp++;
            if (!$onehot0(gnt0) || !$onehot0(gnt1)) begin
                n_fail++;
                $display("FAIL random_onehot c=%0d: got gnt=%b / %b, want zero or one-hot", c, gnt0, gnt1);
            end
            n_cmp++;
            if ((busy0 && gnt0 !== 5'(1 << sel0)) || (busy1 && gnt1 !== 5'(1 << sel1))) begin
                n_fail++;
                $display("FAIL random_select c=%0d: got gnt=%b sel=%0d / gnt=%b sel=%0d, want matching",
                         c, gnt0, sel0, gnt1, sel1);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_single_hold();
        test_handoff();
        test_pulse();
        test_async_reset();
        test_max_hold1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
